uart_tx_fifo: RTL and testbench

- Byte-buffered front end that drives the uart_tx byte handshake (tx_data / tx_data_ready / tx_done) from a write-side FIFO.
- Producers such as the console mux and its arbiter push bytes at clock rate. The block holds them and launches each byte into uart_tx one at a time, only when the transmitter reports idle.
- It is the driving end of the uart_tx interface, replacing the bench-style direct pulsing of tx_data_ready.

---
 rtl/uart_tx_fifo.sv | 120 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds the uart_tx byte handshake, launching one queued byte each time the
// transmitter reports idle, with a retry-free timeout if the busy indication is never seen.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter int unsigned BUSY_TIMEOUT = 15
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            wr_data_i,
   input  logic                  wr_en_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  overflow_o,
   output logic [7:0]            tx_data_o,
   output logic                  tx_data_ready_o,
   input  logic                  tx_done_i
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned TmoW  = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [DEPTH_LOG2:0] DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [TmoW-1:0]     TmoLast  = TmoW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

   state_e                state_q, state_d;
   logic [7:0]            mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic [TmoW-1:0]       tmo_q, tmo_d;
   logic                  full, empty, push, pop;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);
   assign pop   = (state_q == StLaunch);
   // Fullness is judged before the pop, so a write in the launch cycle always fits.
   assign push  = wr_en_i && (!full || pop);

   // FIFO bookkeeping
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (wr_en_i & full & ~pop);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // FSM: state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_data_q  <= 8'h00;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_data_q  <= tx_data_d;
         tmo_q      <= tmo_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (!empty && tx_done_i) state_d = StLaunch;
         StLaunch:   state_d = StWaitBusy;
         StWaitBusy: begin
            if (!tx_done_i)            state_d = StWaitDone;
            else if (tmo_q == TmoLast) state_d = StIdle;
         end
         StWaitDone: if (tx_done_i) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // FSM: outputs. The byte is captured on entry to launch so it is valid alongside the pulse.
   always_comb begin
      tx_data_d       = tx_data_q;
      tmo_d           = tmo_q;
      tx_data_ready_o = 1'b0;
      unique case (state_q)
         StIdle:     if (state_d == StLaunch) tx_data_d = mem_q[rd_ptr_q];
         StLaunch: begin
            tx_data_ready_o = 1'b1;
            tmo_d           = '0;
         end
         StWaitBusy: if (tx_done_i) tmo_d = tmo_q + 1'b1;
         default:    ;
      endcase
   end

   assign full_o     = full;
   assign empty_o    = empty;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter that can run normally,
// hold busy, or stay permanently idle.
module tb_uart_tx_fifo;

   localparam int unsigned DepthLog2   = 4;
   localparam int unsigned BusyTimeout = 15;
   localparam int          BusyLen     = 20;
   localparam int          ModeNormal  = 0;
   localparam int          ModeHold    = 1;
   localparam int          ModeStub    = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [7:0]         wr_data = 8'h00;
   logic               wr_en = 1'b0;
   logic               full, empty, overflow, tx_data_ready;
   logic [DepthLog2:0] count;
   logic [7:0]         tx_data;
   logic               tx_done = 1'b1;

   int         tx_mode = ModeNormal;
   int         busy_cnt = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         pulses = 0;
   int         cyc = 0;
   int         pulse_cyc[$];
   logic [7:0] sb[$];
   logic [7:0] last_tx = 8'h00;
   logic       prev_ready = 1'b0;

   uart_tx_fifo #(
      .DEPTH_LOG2   (DepthLog2),
      .BUSY_TIMEOUT (BusyTimeout)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .wr_data_i       (wr_data),
      .wr_en_i         (wr_en),
      .full_o          (full),
      .empty_o         (empty),
      .count_o         (count),
      .overflow_o      (overflow),
      .tx_data_o       (tx_data),
      .tx_data_ready_o (tx_data_ready),
      .tx_done_i       (tx_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transmitter model: drops tx_done the edge after a launch and stays busy BusyLen cycles.
   always @(posedge clk) begin
      if (tx_mode == ModeHold) begin
         tx_done  <= 1'b0;
         busy_cnt <= 0;
      end else if (tx_mode == ModeStub) begin
         tx_done  <= 1'b1;
         busy_cnt <= 0;
      end else if (tx_data_ready) begin
         tx_done  <= 1'b0;
         busy_cnt <= BusyLen;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         tx_done  <= 1'b1;
      end
   end

   // Monitor: every launch pulse is matched against the scoreboard front.
   always @(negedge clk) begin
      cyc++;
      if (tx_data_ready) begin
         pulses++;
         pulse_cyc.push_back(cyc);
         check_eq("ready_gap", 32'(prev_ready), 32'd0);
         check_eq("ready_while_busy", 32'(tx_done), 32'd1);
         check_eq("pulse_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(sb.pop_front()));
         last_tx = tx_data;
      end
      prev_ready = tx_data_ready;
   end

   task automatic wr(input logic [7:0] b);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b;
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && tx_done && !tx_data_ready && empty) break;
      end
      check_eq("drain_sb_empty", 32'(sb.size()), 32'd0);
      repeat (BusyLen + 4) @(negedge clk);
   endtask

   initial begin
      int p0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_empty", 32'(empty), 32'd1);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_tx_data", 32'(tx_data), 32'h00);
      check_eq("rst_ready", 32'(tx_data_ready), 32'd0);

      // Single byte, launch latency
      sb.push_back(8'hA5);
      wr(8'hA5);
      @(negedge clk);
      check_eq("lat_n1_ready", 32'(tx_data_ready), 32'd0);
      @(negedge clk);
      check_eq("lat_n2_ready", 32'(tx_data_ready), 32'd1);
      wait_drain();
      check_eq("a5_empty", 32'(empty), 32'd1);
      check_eq("a5_count", 32'(count), 32'd0);

      // Burst of 16 while the transmitter is busy, then drain in order
      tx_mode = ModeHold;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         sb.push_back(8'(i));
         wr(8'(i));
      end
      check_eq("burst_full", 32'(full), 32'd1);
      check_eq("burst_count", 32'(count), 32'd16);
      p0 = pulses;
      tx_mode = ModeNormal;
      wait_drain();
      check_eq("burst_pulses", 32'(pulses - p0), 32'd16);
      check_eq("burst_overflow", 32'(overflow), 32'd0);

      // 17 writes into 16 entries
      tx_mode = ModeHold;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) sb.push_back(8'(8'h40 + i));
         wr(8'(8'h40 + i));
      end
      check_eq("ovf_set", 32'(overflow), 32'd1);
      check_eq("ovf_count", 32'(count), 32'd16);
      p0 = pulses;
      tx_mode = ModeNormal;
      wait_drain();
      check_eq("ovf_pulses", 32'(pulses - p0), 32'd16);
      check_eq("ovf_sticky", 32'(overflow), 32'd1);

      // Write while full in the launch cycle
      do_reset();
      @(negedge clk);
      check_eq("rst2_overflow", 32'(overflow), 32'd0);
      tx_mode = ModeHold;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         sb.push_back(8'(8'h80 + i));
         wr(8'(8'h80 + i));
      end
      tx_mode = ModeNormal;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_data_ready) break;
      end
      check_eq("pop_pulse_seen", 32'(tx_data_ready), 32'd1);
      wr_en   = 1'b1;
      wr_data = 8'h7E;
      sb.push_back(8'h7E);
      @(posedge clk);
      #1 wr_en = 1'b0;
      check_eq("pop_wr_count", 32'(count), 32'd16);
      check_eq("pop_wr_full", 32'(full), 32'd1);
      check_eq("pop_wr_overflow", 32'(overflow), 32'd0);
      wait_drain();
      check_eq("pop_wr_last", 32'(last_tx), 32'h7E);

      // Stub transmitter never drops tx_done: every launch times out
      tx_mode = ModeStub;
      repeat (2) @(negedge clk);
      p0 = pulses;
      pulse_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         sb.push_back(8'(8'hC0 + i));
         wr(8'(8'hC0 + i));
      end
      repeat (3 * (BusyTimeout + 2) + 60) @(negedge clk);
      check_eq("stub_pulses", 32'(pulses - p0), 32'd3);
      check_eq("stub_empty", 32'(empty), 32'd1);
      if (pulse_cyc.size() == 3) begin
         check_eq("stub_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(BusyTimeout + 2));
         check_eq("stub_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(BusyTimeout + 2));
      end

      // Reset while waiting for tx_done with five bytes queued
      tx_mode = ModeNormal;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         sb.push_back(8'(8'h10 + i));
         wr(8'(8'h10 + i));
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!tx_done) break;
      end
      check_eq("mid_busy", 32'(tx_done), 32'd0);
      @(negedge clk);
      check_eq("mid_count", 32'(count), 32'd5);
      rst = 1'b1;
      sb.delete();
      #1;
      check_eq("mid_rst_count", 32'(count), 32'd0);
      check_eq("mid_rst_empty", 32'(empty), 32'd1);
      check_eq("mid_rst_full", 32'(full), 32'd0);
      check_eq("mid_rst_tx_data", 32'(tx_data), 32'h00);
      check_eq("mid_rst_ready", 32'(tx_data_ready), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      p0 = pulses;
      repeat (BusyLen + 40) @(negedge clk);
      check_eq("mid_no_pulse", 32'(pulses - p0), 32'd0);
      sb.push_back(8'h3C);
      wr(8'h3C);
      wait_drain();
      check_eq("mid_new_pulse", 32'(pulses - p0), 32'd1);
      check_eq("mid_new_last", 32'(last_tx), 32'h3C);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
